// File: rtl/valid_ready_pipe.sv
// rtl/valid_ready_pipe.sv - chain of valid/ready register slices, forward (MODE 0) or fully registered skid (MODE 1)
// Optional synchronous flush port when VALID_READY_PIPE_FLUSH_EN is defined.
module valid_ready_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1,
  parameter int MODE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VALID_READY_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [WIDTH-1:0] s_data,
  output logic [4:0]       count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} slot_t;

  logic              flush_i;
  logic              run;
  logic              m_hs;
  logic              s_hs;
  logic [STAGES-1:0] vo;
  logic [STAGES-1:0] vi;
  logic [STAGES-1:0] ri;
  logic [STAGES-1:0] ihs;
  logic [WIDTH-1:0]  dout [STAGES];
  logic [WIDTH-1:0]  din  [STAGES];

`ifdef VALID_READY_PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // run keeps the input closed until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_head
      assign vi[g]  = m_valid & run;
      assign din[g] = m_data;
    end else begin : g_body
      assign vi[g]  = vo[g-1];
      assign din[g] = dout[g-1];
    end
  end

  assign ihs     = vi & ri;
  assign m_ready = run & ri[0];
  assign s_valid = vo[STAGES-1];
  assign s_data  = dout[STAGES-1];
  assign m_hs    = m_valid & m_ready;
  assign s_hs    = s_valid & s_ready;

  if (MODE == 0) begin : g_fwd
    // ready ripples back from s_ready; an empty slot always accepts
    always_comb begin
      logic ok;
      ok = s_ready;
      ri = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
        ok    = ok | ~vo[i];
        ri[i] = ok;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vo <= '0;
        for (int i = 0; i < STAGES; i++) dout[i] <= '0;
      end else begin
        for (int i = 0; i < STAGES; i++) begin
          if (flush_i)    vo[i] <= 1'b0;
          else if (ri[i]) vo[i] <= vi[i];
          if (ihs[i]) dout[i] <= din[i];
        end
      end
    end
  end else begin : g_full
    slot_t             st   [STAGES];
    slot_t             nst  [STAGES];
    logic [WIDTH-1:0]  skid [STAGES];
    logic [STAGES-1:0] ro;
    logic [STAGES-1:0] ohs;

    for (genvar g = 0; g < STAGES; g++) begin : g_oready
      if (g == STAGES - 1) begin : g_last
        assign ro[g] = s_ready;
      end else begin : g_mid
        assign ro[g] = ri[g+1];
      end
    end

    assign ohs = vo & ro;

    always_comb begin
      for (int i = 0; i < STAGES; i++) begin
        nst[i] = st[i];
        case (st[i])
          EMPTY:   if (ihs[i]) nst[i] = ONE;
          ONE:     if (ihs[i] && !ohs[i]) nst[i] = TWO;
                   else if (ohs[i] && !ihs[i]) nst[i] = EMPTY;
          TWO:     if (ohs[i]) nst[i] = ONE;
          default: nst[i] = EMPTY;
        endcase
      end
    end

    // main register drives the output; skid catches the beat that arrives while stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vo <= '0;
        ri <= '0;
        for (int i = 0; i < STAGES; i++) begin
          st[i]   <= EMPTY;
          dout[i] <= '0;
          skid[i] <= '0;
        end
      end else begin
        for (int i = 0; i < STAGES; i++) begin
          if (flush_i) begin
            st[i] <= EMPTY;
            vo[i] <= 1'b0;
            ri[i] <= 1'b1;
          end else begin
            st[i] <= nst[i];
            vo[i] <= (nst[i] != EMPTY);
            ri[i] <= (nst[i] != TWO);
          end
          case (st[i])
            EMPTY:   if (ihs[i]) dout[i] <= din[i];
            ONE:     if (ihs[i] && ohs[i]) dout[i] <= din[i];
                     else if (ihs[i]) skid[i] <= din[i];
            TWO:     if (ohs[i]) dout[i] <= skid[i];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count <= '0;
    else if (flush_i)          count <= '0;
    else if (m_hs && !s_hs)    count <= count + 5'd1;
    else if (s_hs && !m_hs)    count <= count - 5'd1;
  end

endmodule
